// File: rtl/ser_arb_pkg.sv
// Shared types and constants for the serializer arbiter and its picker.
// Imported by rr_pick and ser_arbiter.
package ser_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, START, SERVE} ser_arb_state_t;

    localparam int MIN_MOD = 3;

    function automatic int ptr_width(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker: first set request at or after ptr_i,
// wrapping, returned both one-hot and as an index.
module rr_pick
    import ser_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = ptr_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          any_o
);

    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] gnt_dbl;
    logic [N-1:0]   req_rot;
    logic [N-1:0]   gnt_rot;
    logic [PW:0]    sum;
    logic           found;

    // Rotate so ptr_i lands on bit 0, take the lowest set bit, rotate back.
    always_comb begin
        req_dbl = {req_i, req_i} >> ptr_i;
        req_rot = req_dbl[N-1:0];
        gnt_rot = '0;
        sum     = '0;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req_rot[i]) begin
                found      = 1'b1;
                gnt_rot[i] = 1'b1;
                sum        = {1'b0, ptr_i} + (PW+1)'(i);
            end
        end
        if (sum >= (PW+1)'(N)) begin
            sum = sum - (PW+1)'(N);
        end
        idx_o   = sum[PW-1:0];
        gnt_dbl = {gnt_rot, gnt_rot} << ptr_i;
        gnt_o   = gnt_dbl[2*N-1:N];
        any_o   = found;
    end

endmodule

// File: rtl/ser_arbiter.sv
// Round-robin front end for a shared serializer: picks a requester, issues one
// start strobe, follows serializer busy to completion, reports ready/err/done.
//
//  state | meaning
//  IDLE  | pick next request; reject short modifiers in place
//  ISSUE | start strobe high, held while the serializer is still draining
//  START | wait for busy to rise, watchdog running
//  SERVE | wait for busy to fall, then pulse done
module ser_arbiter
    import ser_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 8,
    parameter int VAL_BITS = 3,
    parameter int WD_CYC   = 4
) (
    input  logic                      clk_i,
    input  logic                      arst_n_i,
    input  logic [N_REQ-1:0]          req_val_i,
    input  logic [N_REQ*WIDTH-1:0]    req_data_i,
    input  logic [N_REQ*VAL_BITS-1:0] req_mod_i,
    output logic [N_REQ-1:0]          req_ready_o,
    output logic [N_REQ-1:0]          req_err_o,
    output logic [N_REQ-1:0]          req_done_o,
    output logic [N_REQ-1:0]          grant_o,
    output logic                      ser_data_val_o,
    output logic [WIDTH-1:0]          ser_data_o,
    output logic [VAL_BITS-1:0]       ser_data_mod_o,
    input  logic                      ser_busy_i,
    output logic                      busy_o
);

    localparam int PW  = ptr_width(N_REQ);
    localparam int WDW = $clog2(WD_CYC + 1);

    ser_arb_state_t      state_q, state_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic [N_REQ-1:0]    ready_q, ready_d;
    logic [N_REQ-1:0]    err_q, err_d;
    logic [N_REQ-1:0]    done_q, done_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic [VAL_BITS-1:0] mod_q, mod_d;
    logic [WDW-1:0]      wd_q, wd_d;

    logic [N_REQ-1:0]    pick_gnt;
    logic [PW-1:0]       pick_idx;
    logic                pick_any;
    logic [PW-1:0]       ptr_inc;
    logic [WIDTH-1:0]    pick_data;
    logic [VAL_BITS-1:0] pick_mod;

    rr_pick #(
        .N  (N_REQ),
        .PW (PW)
    ) u_pick (
        .req_i (req_val_i),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    assign pick_data = req_data_i[int'(pick_idx)*WIDTH +: WIDTH];
    assign pick_mod  = req_mod_i[int'(pick_idx)*VAL_BITS +: VAL_BITS];
    assign ptr_inc   = (pick_idx == PW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        ready_d = '0;
        err_d   = '0;
        done_d  = '0;
        data_d  = data_q;
        mod_d   = mod_q;
        wd_d    = wd_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    ptr_d = ptr_inc;
                    if (pick_mod < VAL_BITS'(MIN_MOD)) begin
                        err_d = pick_gnt;
                    end else begin
                        ready_d = pick_gnt;
                        grant_d = pick_gnt;
                        data_d  = pick_data;
                        mod_d   = pick_mod;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                // The serializer latches the word on the edge that leaves ISSUE.
                if (!ser_busy_i) begin
                    wd_d    = '0;
                    state_d = START;
                end
            end
            START: begin
                if (ser_busy_i) begin
                    wd_d    = '0;
                    state_d = SERVE;
                end else if (wd_q == WDW'(WD_CYC - 1)) begin
                    err_d   = grant_q;
                    grant_d = '0;
                    wd_d    = '0;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            SERVE: begin
                if (!ser_busy_i) begin
                    done_d  = grant_q;
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            ready_q <= '0;
            err_q   <= '0;
            done_q  <= '0;
            data_q  <= '0;
            mod_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            done_q  <= done_d;
            data_q  <= data_d;
            mod_q   <= mod_d;
            wd_q    <= wd_d;
        end
    end

    assign req_ready_o    = ready_q;
    assign req_err_o      = err_q;
    assign req_done_o     = done_q;
    assign grant_o        = grant_q;
    assign ser_data_val_o = (state_q == ISSUE);
    assign ser_data_o     = data_q;
    assign ser_data_mod_o = mod_q;
    assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_ser_arbiter.sv
// Scoreboard bench for ser_arbiter with a behavioural serializer model;
// directed scenarios push expected pulses/captures, a negedge monitor checks them.
module tb_ser_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int VB = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              arst_n;
    logic [N-1:0]      req_val;
    logic [N*W-1:0]    req_data;
    logic [N*VB-1:0]   req_mod;
    logic [N-1:0]      req_ready, req_err, req_done, grant;
    logic              ser_val;
    logic [W-1:0]      ser_data;
    logic [VB-1:0]     ser_mod;
    logic              ser_busy;
    logic              busy;

    logic              force_busy;
    logic              model_en;
    logic              busy_m;
    logic [W-1:0]      shreg;
    int                cnt;

    assign ser_busy = force_busy | busy_m;

    ser_arbiter #(
        .N_REQ    (N),
        .WIDTH    (W),
        .VAL_BITS (VB),
        .WD_CYC   (4)
    ) dut (
        .clk_i          (clk),
        .arst_n_i       (arst_n),
        .req_val_i      (req_val),
        .req_data_i     (req_data),
        .req_mod_i      (req_mod),
        .req_ready_o    (req_ready),
        .req_err_o      (req_err),
        .req_done_o     (req_done),
        .grant_o        (grant),
        .ser_data_val_o (ser_val),
        .ser_data_o     (ser_data),
        .ser_data_mod_o (ser_mod),
        .ser_busy_i     (ser_busy),
        .busy_o         (busy)
    );

    typedef struct {
        int kind;
        int idx;
        int cyc;
    } evt_t;

    typedef struct {
        logic [W-1:0]  d;
        logic [VB-1:0] m;
    } cap_t;

    evt_t evq[$];
    cap_t capq[$];
    int   bitq[$];

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int val_cnt = 0;
    int cap_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic string kind_name(input int kind);
        case (kind)
            0:       return "ready";
            1:       return "err";
            default: return "done";
        endcase
    endfunction

    task automatic check_pulse(input int kind, input logic [N-1:0] v);
        evt_t e;
        if (v != '0) begin
            if (evq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_%s: got vector %b expected no pulse (cycle %0d)",
                         kind_name(kind), v, cyc);
            end else begin
                e = evq.pop_front();
                check({"evt_kind_", kind_name(kind)}, kind, e.kind);
                check({"evt_vec_", kind_name(kind)}, int'(v), 1 << e.idx);
                check({"evt_cycle_", kind_name(kind)}, cyc, e.cyc);
                if (kind == 0) check("grant_with_ready", int'(grant), int'(v));
            end
        end
    endtask

    // Monitor: pulses, start strobes and serializer captures, sampled mid-cycle.
    always @(negedge clk) begin
        cap_t c;
        if (ser_val) val_cnt++;
        check_pulse(0, req_ready);
        check_pulse(1, req_err);
        check_pulse(2, req_done);
        if (arst_n && model_en && !busy_m && ser_val && !ser_busy) begin
            cap_cnt++;
            if (capq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_capture: got data %h expected none (cycle %0d)", ser_data, cyc);
            end else begin
                c = capq.pop_front();
                check("cap_data", int'(ser_data), int'(c.d));
                check("cap_mod", int'(ser_mod), int'(c.m));
            end
        end
        if (arst_n && model_en && busy_m && bitq.size() > 0) begin
            check("ser_bit", int'(shreg[W-1]), bitq.pop_front());
        end
    end

    // Serializer model: latches on strobe while idle, busy for mod cycles, MSB first.
    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            busy_m <= 1'b0;
            cnt    <= 0;
            shreg  <= '0;
        end else if (model_en) begin
            if (busy_m) begin
                shreg <= shreg << 1;
                cnt   <= cnt - 1;
                if (cnt == 1) busy_m <= 1'b0;
            end else if (ser_val && !ser_busy) begin
                shreg  <= ser_data;
                cnt    <= int'(ser_mod);
                busy_m <= (ser_mod != '0);
            end
        end
    end

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_req(input int k, input logic v, input logic [W-1:0] d, input logic [VB-1:0] m);
        req_val[k]          = v;
        req_data[k*W +: W]  = d;
        req_mod[k*VB +: VB] = m;
    endtask

    task automatic exp_evt(input int kind, input int idx, input int c);
        evt_t e;
        e.kind = kind;
        e.idx  = idx;
        e.cyc  = c;
        evq.push_back(e);
    endtask

    task automatic exp_cap(input logic [W-1:0] d, input logic [VB-1:0] m);
        cap_t c;
        c.d = d;
        c.m = m;
        capq.push_back(c);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, int'(req_ready), 0);
        check({tag, "_err"}, int'(req_err), 0);
        check({tag, "_done"}, int'(req_done), 0);
        check({tag, "_grant"}, int'(grant), 0);
        check({tag, "_ser_val"}, int'(ser_val), 0);
        check({tag, "_ser_data"}, int'(ser_data), 0);
        check({tag, "_ser_mod"}, int'(ser_mod), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        int c;
        arst_n     = 1'b0;
        req_val    = '0;
        req_data   = '0;
        req_mod    = '0;
        force_busy = 1'b0;
        model_en   = 1'b1;
        #3;
        check_all_zero("reset");
        wait_cyc(2);
        arst_n = 1'b1;
        wait_cyc(3);

        // Single requester 1, word 0xB4, mod 5.
        c = cyc;
        val_cnt = 0;
        set_req(1, 1'b1, 8'hB4, 3'd5);
        exp_evt(0, 1, c + 1);
        exp_evt(2, 1, c + 8);
        exp_cap(8'hB4, 3'd5);
        bitq.push_back(1); bitq.push_back(0); bitq.push_back(1);
        bitq.push_back(1); bitq.push_back(0);
        wait_cyc(c + 1);
        set_req(1, 1'b0, 8'h00, 3'd0);
        check("single_busy_c1", int'(busy), 1);
        wait_cyc(c + 10);
        check("single_val_cycles", val_cnt, 1);
        check("single_idle", int'(busy), 0);

        // Reject: requester 2 mod 2 rejected, requester 3 mod 7 accepted next.
        c = cyc;
        val_cnt = 0;
        set_req(2, 1'b1, 8'hC3, 3'd2);
        set_req(3, 1'b1, 8'h3C, 3'd7);
        exp_evt(1, 2, c + 1);
        exp_evt(0, 3, c + 2);
        exp_evt(2, 3, c + 11);
        exp_cap(8'h3C, 3'd7);
        wait_cyc(c + 1);
        set_req(2, 1'b0, 8'h00, 3'd0);
        check("reject_no_val", int'(ser_val), 0);
        check("reject_idle", int'(busy), 0);
        wait_cyc(c + 2);
        set_req(3, 1'b0, 8'h00, 3'd0);
        wait_cyc(c + 13);
        check("reject_val_cycles", val_cnt, 1);

        // Fairness: all requesters valid, mod 3; order 0,1,2,3,0,1.
        c = cyc;
        for (int k = 0; k < N; k++) set_req(k, 1'b1, 8'(8'h10 + k), 3'd3);
        for (int i = 0; i < 6; i++) begin
            exp_evt(0, i % N, c + 1 + 6*i);
            exp_evt(2, i % N, c + 6 + 6*i);
            exp_cap(8'(8'h10 + (i % N)), 3'd3);
        end
        wait_cyc(c + 32);
        for (int k = 0; k < N; k++) set_req(k, 1'b0, 8'h00, 3'd0);
        wait_cyc(c + 38);

        // Busy collision: busy forced high for the first 3 ISSUE cycles.
        c = cyc;
        val_cnt = 0;
        cap_cnt = 0;
        set_req(2, 1'b1, 8'h96, 3'd4);
        exp_evt(0, 2, c + 1);
        exp_evt(2, 2, c + 10);
        exp_cap(8'h96, 3'd4);
        wait_cyc(c + 1);
        set_req(2, 1'b0, 8'h00, 3'd0);
        force_busy = 1'b1;
        wait_cyc(c + 4);
        force_busy = 1'b0;
        wait_cyc(c + 12);
        check("collision_val_cycles", val_cnt, 4);
        check("collision_captures", cap_cnt, 1);

        // Watchdog: serializer never raises busy.
        c = cyc;
        model_en = 1'b0;
        set_req(1, 1'b1, 8'h77, 3'd4);
        exp_evt(0, 1, c + 1);
        exp_evt(1, 1, c + 6);
        wait_cyc(c + 1);
        set_req(1, 1'b0, 8'h00, 3'd0);
        wait_cyc(c + 5);
        check("wd_busy_before", int'(busy), 1);
        wait_cyc(c + 6);
        check("wd_grant_cleared", int'(grant), 0);
        check("wd_idle", int'(busy), 0);
        wait_cyc(c + 8);
        model_en = 1'b1;

        // Reset mid-SERVE, then pointer restarts at requester 0.
        c = cyc;
        set_req(2, 1'b1, 8'h5A, 3'd7);
        exp_evt(0, 2, c + 1);
        exp_cap(8'h5A, 3'd7);
        wait_cyc(c + 1);
        set_req(2, 1'b0, 8'h00, 3'd0);
        wait_cyc(c + 4);
        check("rst_serving", int'(busy), 1);
        #2;
        arst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        wait_cyc(c + 6);
        arst_n = 1'b1;
        wait_cyc(c + 7);
        set_req(0, 1'b1, 8'h11, 3'd3);
        set_req(3, 1'b1, 8'hEE, 3'd3);
        exp_evt(0, 0, c + 8);
        exp_evt(2, 0, c + 13);
        exp_evt(0, 3, c + 14);
        exp_evt(2, 3, c + 19);
        exp_cap(8'h11, 3'd3);
        exp_cap(8'hEE, 3'd3);
        wait_cyc(c + 9);
        set_req(0, 1'b0, 8'h00, 3'd0);
        wait_cyc(c + 15);
        set_req(3, 1'b0, 8'h00, 3'd0);
        wait_cyc(c + 22);

        check("evq_drained", evq.size(), 0);
        check("capq_drained", capq.size(), 0);
        check("bitq_drained", bitq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ser_arbiter.md
# ser_arbiter

Round-robin scheduler that shares one serializer between `N_REQ` requesters. It accepts per-requester words with a length modifier and rejects modifiers below `MIN_MOD`. It issues one start to the serializer, tracks the serializer's `busy` through to completion, and reports accept, reject and done per requester. It sits directly in front of the serializer instance in the serial-output path.

## Interface
- `N_REQ`, 4, number of requesters (≥2)
- `WIDTH`, 8, data word width; must match the serializer
- `VAL_BITS`, 3, modifier width; must match the serializer
- `WD_CYC`, 4, watchdog limit in cycles for the serializer to raise busy after a start
- `clk_i` in 1: single clock; all logic is on the rising edge
- `arst_n_i` in 1: reset, asynchronous and active-low
- `req_val_i` in `N_REQ`: request pending, one bit per requester
- `req_data_i` in `N_REQ*WIDTH`: flattened words; requester k occupies `[k*WIDTH +: WIDTH]`
- `req_mod_i` in `N_REQ*VAL_BITS`: flattened modifiers (bit count)
- `req_ready_o` out `N_REQ`: one-cycle accept pulse
- `req_err_o` out `N_REQ`: one-cycle reject pulse (modifier < `MIN_MOD`, or watchdog expiry)
- `req_done_o` out `N_REQ`: one-cycle pulse when the serializer finishes the word
- `grant_o` out `N_REQ`: one-hot owner, held from accept through done
- `ser_data_val_o` out 1: start strobe to the serializer
- `ser_data_o` out `WIDTH`: word to the serializer, registered
- `ser_data_mod_o` out `VAL_BITS`: modifier to the serializer, registered
- `ser_busy_i` in 1: serializer busy
- `busy_o` out 1: high whenever state ≠ IDLE

## Operation
- FSM states:
  - IDLE: wait for a request.
  - ISSUE: start strobe high.
  - START: wait for serializer busy to rise.
  - SERVE: wait for serializer busy to fall.
- In IDLE, the combinational picker selects the first `req_val_i[k]` searching from `ptr`, wrapping modulo `N_REQ`.
  - If `req_mod_i[k] < MIN_MOD`: `req_err_o[k]` pulses, `ptr ← k+1` (wraps), FSM stays in IDLE.
  - Otherwise:
    - `req_ready_o[k]` pulses.
    - Data and modifier are registered onto `ser_data_o` / `ser_data_mod_o`.
    - `grant_o[k]` is set, `ptr ← k+1`, and the FSM moves to ISSUE.
- ISSUE: `ser_data_val_o`=1.
  - While `ser_busy_i`=1 (previous word still draining), hold ISSUE.
  - On the first cycle with `ser_busy_i`=0, move to START; the serializer captures the word on that edge.
- START: `ser_data_val_o`=0; the watchdog counter increments each cycle.
  - `ser_busy_i`=1 → SERVE, watchdog cleared.
  - Counter reaches `WD_CYC` → `req_err_o[k]` pulses, grant cleared, → IDLE.
- SERVE: on `ser_busy_i`=0, `req_done_o[k]` pulses, grant cleared, → IDLE.
- A requester must hold `req_val_i` and its data stable until it sees `ready` or `err`. Data changes after `ready` have no effect.
- Requests arriving while the FSM is not in IDLE wait; nothing is queued internally.
- `ser_data_o` and `ser_data_mod_o` hold their last value between transfers.

## Timing
- Reset (asynchronous, active-low) values: all outputs 0, state IDLE, `ptr`=0, watchdog 0. Asserting reset mid-transfer aborts the transfer with no done or err pulse.
- Request high in cycle 0 (FSM in IDLE, serializer idle):
  - Cycle 1: `ready`, `grant`, `ser_data_val_o`.
  - Cycle 2: START, serializer `busy` high.
  - Cycle 3: SERVE.
  - `done` in the cycle after `ser_busy_i` is first seen low in SERVE.
- Reject path: err pulse in cycle 1, FSM in IDLE again in cycle 1, so the next pick happens in cycle 1.
- After `done`, the earliest next accept is the following cycle; there is 1 idle cycle minimum between words.
- `ser_data_val_o` is never high in two consecutive cycles while `ser_busy_i`=0.

## Structure
- Package `ser_arb_pkg`:
  - `typedef enum logic [1:0] {IDLE, ISSUE, START, SERVE} ser_arb_state_t`
  - `localparam MIN_MOD = 3`
  - Function returning the width of `ptr` as `$clog2(N_REQ)`.
- Sub-module `rr_pick`: combinational rotate-priority one-hot selector.
  - Inputs: request vector and `ptr`.
  - Outputs: one-hot grant vector and its index.
  - Reusable by other arbiters.

## Test plan
- Single requester: requester 1 sends word `0xB4`, mod 5 → `ready[1]` in cycle 1; serializer emits 1,0,1,1,0; `done[1]` once after busy falls.
- Reject: requester 2 sends mod 2 → `err[2]` pulse, `ser_data_val_o` never asserted; requester 3 sends mod 7 in the same cycle → accepted in the following cycle.
- Fairness: all 4 requesters valid continuously, mod 3 → grant order 0,1,2,3,0,1; no requester is granted twice before every other valid one is served.
- Busy collision: force `ser_busy_i`=1 during ISSUE for 3 cycles → `ser_data_val_o` held high 4 cycles, exactly one capture.
- Watchdog: `ser_busy_i` tied 0 after issue → `err[k]` 4 cycles after START entry, FSM back in IDLE, `grant_o`=0.
- Reset mid-SERVE: drop `arst_n_i` asynchronously → all outputs 0 immediately; `ptr`=0 so requester 0 is granted first after release.
